// File: rtl/branch_pkg.sv
// Shared types for the branch flag unit: ARM condition codes, branch kinds,
// the NZCV flag record and the hazard FSM states.
package branch_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, HS = 4'h2, LO = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    B_COND   = 2'b00,
    CBZ      = 2'b01,
    CBNZ     = 2'b10,
    B_UNCOND = 2'b11
  } br_type_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } fsm_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator: (NZCV, cond) -> taken.
module cond_eval
  import branch_pkg::*;
(
  input  nzcv_t flags,
  input  cond_e cond,
  output logic  taken
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    taken = 1'b1;
    case (cond)
      EQ: taken = flags.z;
      NE: taken = !flags.z;
      HS: taken = flags.c;
      LO: taken = !flags.c;
      MI: taken = flags.n;
      PL: taken = !flags.n;
      VS: taken = flags.v;
      VC: taken = !flags.v;
      HI: taken = flags.c && !flags.z;
      LS: taken = !flags.c || flags.z;
      GE: taken = (flags.n == flags.v);
      LT: taken = (flags.n != flags.v);
      GT: taken = !flags.z && (flags.n == flags.v);
      LE: taken = flags.z || (flags.n != flags.v);
      default: taken = 1'b1; // AL and NV both resolve taken
    endcase
  end

endmodule

// File: rtl/branch_flag_unit.sv
// Latches ALU NZCV flags and resolves B.cond/CBZ/CBNZ/B into a registered taken/done pulse.
// Define BRANCH_FLAG_FWD_EN to forward EX flags to B.cond instead of stalling in HOLD.
module branch_flag_unit
  import branch_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              set_flags,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_carry_out,
  input  logic              pipe_stall,
  input  logic              br_valid,
  input  logic [1:0]        br_type,
  input  logic [3:0]        br_cond,
  input  logic [DATA_W-1:0] br_reg,
  output logic [3:0]        flags_q,
  output logic              br_done,
  output logic              br_taken,
  output logic              busy
);

  nzcv_t             nzcv_q, nzcv_d;
  fsm_e              state_q, state_d;
  br_type_e          hold_type_q, hold_type_d;
  cond_e             hold_cond_q, hold_cond_d;
  logic [DATA_W-1:0] hold_reg_q, hold_reg_d;
  logic              br_done_q, br_done_d;
  logic              br_taken_q, br_taken_d;

  nzcv_t             alu_flags;
  logic              flag_gen;
  logic              hazard;
  nzcv_t             idle_flags;

  br_type_e          ev_type;
  cond_e             ev_cond;
  logic [DATA_W-1:0] ev_reg;
  nzcv_t             ev_flags;
  logic              cond_taken;
  logic              decision;

  assign alu_flags = '{n: alu_negative, z: alu_zero, c: alu_carry_out, v: alu_overflow};
  assign flag_gen  = ex_valid && set_flags;

`ifdef BRANCH_FLAG_FWD_EN
  assign hazard     = 1'b0;
  assign idle_flags = flag_gen ? alu_flags : nzcv_q;
  assign busy       = 1'b0;
`else
  assign hazard     = (br_type_e'(br_type) == B_COND) && flag_gen;
  assign idle_flags = nzcv_q;
  assign busy       = (state_q == HOLD);
`endif

  // In HOLD the latched request is resolved against the already-updated flag register.
  always_comb begin
    if (state_q == HOLD) begin
      ev_type  = hold_type_q;
      ev_cond  = hold_cond_q;
      ev_reg   = hold_reg_q;
      ev_flags = nzcv_q;
    end else begin
      ev_type  = br_type_e'(br_type);
      ev_cond  = cond_e'(br_cond);
      ev_reg   = br_reg;
      ev_flags = idle_flags;
    end
  end

  cond_eval u_cond_eval (
    .flags (ev_flags),
    .cond  (ev_cond),
    .taken (cond_taken)
  );

  always_comb begin
    decision = 1'b1;
    case (ev_type)
      B_COND:  decision = cond_taken;
      CBZ:     decision = (ev_reg == '0);
      CBNZ:    decision = (ev_reg != '0);
      default: decision = 1'b1;
    endcase
  end

  always_comb begin
    nzcv_d      = nzcv_q;
    state_d     = state_q;
    hold_type_d = hold_type_q;
    hold_cond_d = hold_cond_q;
    hold_reg_d  = hold_reg_q;
    br_done_d   = 1'b0;
    br_taken_d  = br_taken_q;

    if (flag_gen && !pipe_stall) nzcv_d = alu_flags;

    case (state_q)
      IDLE: begin
        if (br_valid && !pipe_stall) begin
          if (hazard) begin
            hold_type_d = br_type_e'(br_type);
            hold_cond_d = cond_e'(br_cond);
            hold_reg_d  = br_reg;
            state_d     = HOLD;
          end else begin
            br_done_d  = 1'b1;
            br_taken_d = decision;
          end
        end
      end
      HOLD: begin
        if (!pipe_stall) begin
          br_done_d  = 1'b1;
          br_taken_d = decision;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv_q     <= '0;
      state_q    <= IDLE;
      br_done_q  <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      nzcv_q     <= nzcv_d;
      state_q    <= state_d;
      br_done_q  <= br_done_d;
      br_taken_q <= br_taken_d;
    end
  end

  // NOTE: the request latch is not reset; it is only read in HOLD, which always follows a load.
  always_ff @(posedge clk) begin
    hold_type_q <= hold_type_d;
    hold_cond_q <= hold_cond_d;
    hold_reg_q  <= hold_reg_d;
  end

  assign flags_q  = nzcv_q;
  assign br_done  = br_done_q;
  assign br_taken = br_taken_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Self-checking bench for branch_flag_unit: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the flag/branch rules.
module tb_branch_flag_unit;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              ex_valid, set_flags;
  logic              alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic              pipe_stall;
  logic              br_valid;
  logic [1:0]        br_type;
  logic [3:0]        br_cond;
  logic [DATA_W-1:0] br_reg;
  logic [3:0]        flags_q;
  logic              br_done, br_taken, busy;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit [3:0]  m_flags;
  bit        m_pend;
  bit [1:0]  p_type;
  bit [3:0]  p_cond;
  bit [63:0] p_reg;
  bit        m_done, m_taken;

  branch_flag_unit #(.DATA_W(DATA_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .set_flags     (set_flags),
    .alu_negative  (alu_negative),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .alu_carry_out (alu_carry_out),
    .pipe_stall    (pipe_stall),
    .br_valid      (br_valid),
    .br_type       (br_type),
    .br_cond       (br_cond),
    .br_reg        (br_reg),
    .flags_q       (flags_q),
    .br_done       (br_done),
    .br_taken      (br_taken),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Condition codes pair up: even code tests a predicate, odd code its inverse.
  function automatic bit decide(bit [1:0] t, bit [3:0] c, bit [63:0] r, bit [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (t == 2'd1) return r == 64'd0;
    if (t == 2'd2) return r != 64'd0;
    if (t == 2'd3) return 1'b1;
    if (c >= 4'd14) return 1'b1;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      default: base = !z && (n == v);
    endcase
    return base ^ c[0];
  endfunction

  task automatic clear_inputs();
    reset = 0; ex_valid = 0; set_flags = 0;
    alu_negative = 0; alu_zero = 0; alu_overflow = 0; alu_carry_out = 0;
    pipe_stall = 0; br_valid = 0; br_type = 0; br_cond = 0; br_reg = '0;
  endtask

  task automatic set_alu(input bit n, input bit z, input bit c, input bit v);
    ex_valid = 1; set_flags = 1;
    alu_negative = n; alu_zero = z; alu_carry_out = c; alu_overflow = v;
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    bit [3:0] alu;
    bit gen;
    alu = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
    gen = ex_valid && set_flags;
    if (reset) begin
      m_flags = 0; m_pend = 0; m_done = 0; m_taken = 0;
    end else begin
      m_done = 0;
      if (!pipe_stall) begin
        if (m_pend) begin
          m_done  = 1;
          m_taken = decide(p_type, p_cond, p_reg, m_flags);
          m_pend  = 0;
        end else if (br_valid) begin
`ifdef BRANCH_FLAG_FWD_EN
          m_done  = 1;
          m_taken = decide(br_type, br_cond, br_reg, gen ? alu : m_flags);
`else
          if (br_type == 2'd0 && gen) begin
            m_pend = 1; p_type = br_type; p_cond = br_cond; p_reg = br_reg;
          end else begin
            m_done  = 1;
            m_taken = decide(br_type, br_cond, br_reg, m_flags);
          end
`endif
        end
        if (gen) m_flags = alu;
      end
    end
    @(posedge clk);
    #1;
    check("flags", flags_q, m_flags);
    check("done", br_done, m_done);
    check("taken", br_taken, m_taken);
    check("busy", busy, m_pend);
  endtask

  task automatic branch(input bit [1:0] t, input bit [3:0] c, input bit [63:0] r);
    br_valid = 1; br_type = t; br_cond = c; br_reg = r;
    tick();
    br_valid = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    check("rst_flags", flags_q, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", br_done, 1'b0);

    // 1: SUBS 5-5 -> Z=1,C=1
    set_alu(0, 1, 1, 0);
    tick();
    clear_inputs();
    tick();
    tick();
    branch(2'd0, 4'h0, '0);
    check("t1_eq_done", br_done, 1'b1);
    check("t1_eq_taken", br_taken, 1'b1);
    branch(2'd0, 4'h1, '0);
    check("t1_ne_taken", br_taken, 1'b0);

    // 2: signed compares
    set_alu(1, 0, 0, 0);
    tick();
    clear_inputs();
    branch(2'd0, 4'hA, '0);
    check("t2_ge", br_taken, 1'b0);
    branch(2'd0, 4'hB, '0);
    check("t2_lt", br_taken, 1'b1);
    set_alu(1, 0, 0, 1);
    tick();
    clear_inputs();
    branch(2'd0, 4'hC, '0);
    check("t2_gt", br_taken, 1'b1);

    // 3: same-cycle flag hazard on B.cond EQ
    set_alu(0, 0, 0, 0);
    tick();
    set_alu(0, 1, 0, 0);
    branch(2'd0, 4'h0, '0);
    clear_inputs();
`ifdef BRANCH_FLAG_FWD_EN
    check("t3_fwd_done", br_done, 1'b1);
    check("t3_fwd_taken", br_taken, 1'b1);
    check("t3_fwd_busy", busy, 1'b0);
`else
    check("t3_busy", busy, 1'b1);
    check("t3_nodone", br_done, 1'b0);
    tick();
    check("t3_done", br_done, 1'b1);
    check("t3_taken", br_taken, 1'b1);
    check("t3_busy_clr", busy, 1'b0);
`endif
    tick();

    // 4: CBZ/CBNZ during flag writes never hazard
    set_alu(1, 0, 1, 0);
    branch(2'd1, 4'h0, 64'd0);
    check("t4_cbz0_done", br_done, 1'b1);
    check("t4_cbz0", br_taken, 1'b1);
    check("t4_cbz0_busy", busy, 1'b0);
    branch(2'd2, 4'h0, 64'h8000_0000_0000_0000);
    check("t4_cbnz", br_taken, 1'b1);
    branch(2'd1, 4'h0, 64'h8000_0000_0000_0000);
    check("t4_cbz_nz_done", br_done, 1'b1);
    check("t4_cbz_nz", br_taken, 1'b0);
    clear_inputs();
    tick();

    // 5: stall held in HOLD, younger flag writes and requests ignored
    set_alu(0, 0, 0, 0);
    tick();
    set_alu(0, 1, 0, 0);
    branch(2'd0, 4'h0, '0);
    for (int i = 0; i < 3; i++) begin
      pipe_stall = 1;
      set_alu(1, 0, 0, 1);
      br_valid = 1; br_type = 2'd3;
      tick();
      check("t5_stall_nodone", br_done, 1'b0);
      check("t5_stall_flags", flags_q, 4'b0100);
    end
    clear_inputs();
    tick();
    check("t5_release_done", br_done, 1'b1);
    check("t5_release_taken", br_taken, 1'b1);
    tick();
    check("t5_single_pulse", br_done, 1'b0);

    // 6: reset while holding
    set_alu(0, 1, 0, 0);
    branch(2'd0, 4'h0, '0);
    clear_inputs();
    reset = 1;
    tick();
    check("t6_busy", busy, 1'b0);
    check("t6_done", br_done, 1'b0);
    check("t6_flags", flags_q, 4'h0);
    reset = 0;
    tick();
    check("t6_no_stale", br_done, 1'b0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      pipe_stall   = ($urandom_range(0, 4) == 0);
      ex_valid     = $urandom_range(0, 1);
      set_flags    = $urandom_range(0, 1);
      alu_negative = $urandom_range(0, 1);
      alu_zero     = $urandom_range(0, 1);
      alu_overflow = $urandom_range(0, 1);
      alu_carry_out= $urandom_range(0, 1);
      br_valid     = ($urandom_range(0, 2) != 0);
      br_type      = 2'($urandom_range(0, 3));
      br_cond      = 4'($urandom_range(0, 15));
      br_reg       = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
